process_scheduler: RTL and testbench

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

---
 rtl/process_scheduler.sv | 157 +++++++++++++++
 tb/tb_process_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/process_scheduler.sv
// Time-sliced partition scheduler: the OS (partition 0) dispatches processes 1..3.
// A process runs until it halts, yields, or uses up its quantum of retired instructions.
module process_scheduler #(
    parameter int ADDR_WIDTH   = 13,
    parameter int OFFSET_WIDTH = 9,
    parameter int QUANTUM      = 64
) (
    input  logic                    Fast_Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [OFFSET_WIDTH-1:0] Local_PC,
    input  logic [OFFSET_WIDTH-1:0] Next_Local_PC,
    input  logic                    Syscall,
    input  logic                    Halt,
    input  logic                    Dispatch,
    input  logic [1:0]              Dispatch_Id,
    output logic [ADDR_WIDTH-1:0]   PC,
    output logic [1:0]              Cur_Id,
    output logic                    Load_PC,
    output logic [OFFSET_WIDTH-1:0] Load_Offset,
    output logic                    Stall,
    output logic [1:0]              Switch_Cause,
    output logic [1:0]              Last_Id,
    output logic [2:0]              Done_Mask,
    output logic                    All_Done,
    output logic                    Dispatch_Err
);

    typedef enum logic [1:0] {
        RUN_OS   = 2'd0,
        RUN_PROC = 2'd1,
        SWITCH   = 2'd2
    } state_t;

    localparam logic [15:0] QUANTUM_LAST = 16'(QUANTUM - 1);

    state_t                  state_reg;
    logic [1:0]              cur_id_reg;
    logic [15:0]             count_reg;
    logic                    load_pc_reg;
    logic [OFFSET_WIDTH-1:0] load_offset_reg;
    logic                    stall_reg;
    logic [1:0]              cause_reg;
    logic [1:0]              last_id_reg;
    logic                    err_reg;

    logic [4*OFFSET_WIDTH-1:0] saved_pc_flat;
    logic [2:0]                done_mask_w;
    logic [3:0]                done_by_id;
    logic [OFFSET_WIDTH-1:0]   dispatch_pc;
    logic                      dispatch_ok;
    logic                      in_proc;
    logic                      quantum_hit;
    logic                      halt_exit;
    logic                      save_exit;

    assign in_proc     = (state_reg == RUN_PROC) && Enable;
    assign quantum_hit = (count_reg == QUANTUM_LAST);
    assign halt_exit   = in_proc && Halt;
    assign save_exit   = in_proc && !Halt && (Syscall || quantum_hit);

    // Slot 0 stands for the OS: treated as permanently "done" so dispatching it is rejected.
    assign done_by_id  = {done_mask_w, 1'b1};
    assign dispatch_ok = !done_by_id[Dispatch_Id];
    assign dispatch_pc = saved_pc_flat[Dispatch_Id*OFFSET_WIDTH +: OFFSET_WIDTH];
    assign saved_pc_flat[OFFSET_WIDTH-1:0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_proc
            logic [OFFSET_WIDTH-1:0] saved_pc_reg;
            logic                    done_reg;
            logic                    is_cur;

            assign is_cur = (cur_id_reg == 2'(gi));

            always_ff @(posedge Fast_Clock or negedge Reset) begin
                if (!Reset) begin
                    saved_pc_reg <= '0;
                    done_reg     <= 1'b0;
                end else begin
                    if (save_exit && is_cur)
                        saved_pc_reg <= Next_Local_PC;
                    if (halt_exit && is_cur)
                        done_reg <= 1'b1;
                end
            end

            assign saved_pc_flat[gi*OFFSET_WIDTH +: OFFSET_WIDTH] = saved_pc_reg;
            assign done_mask_w[gi-1] = done_reg;
        end
    endgenerate

    always_ff @(posedge Fast_Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= RUN_OS;
            cur_id_reg      <= 2'd0;
            count_reg       <= 16'd0;
            load_pc_reg     <= 1'b0;
            load_offset_reg <= '0;
            stall_reg       <= 1'b0;
            cause_reg       <= 2'd0;
            last_id_reg     <= 2'd0;
            err_reg         <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                RUN_OS: begin
                    if (Enable && Dispatch) begin
                        if (dispatch_ok) begin
                            state_reg       <= SWITCH;
                            cur_id_reg      <= Dispatch_Id;
                            load_offset_reg <= dispatch_pc;
                            load_pc_reg     <= 1'b1;
                            stall_reg       <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                RUN_PROC: begin
                    if (Enable) begin
                        count_reg <= count_reg + 16'd1;
                        if (halt_exit || save_exit) begin
                            state_reg       <= SWITCH;
                            last_id_reg     <= cur_id_reg;
                            cur_id_reg      <= 2'd0;
                            load_offset_reg <= '0;
                            load_pc_reg     <= 1'b1;
                            stall_reg       <= 1'b1;
                            cause_reg       <= halt_exit ? 2'd3 : (Syscall ? 2'd2 : 2'd1);
                        end
                    end
                end
                SWITCH: begin
                    load_pc_reg <= 1'b0;
                    stall_reg   <= 1'b0;
                    count_reg   <= 16'd0;
                    state_reg   <= (cur_id_reg != 2'd0) ? RUN_PROC : RUN_OS;
                end
                default: state_reg <= RUN_OS;
            endcase
        end
    end

    assign PC           = ADDR_WIDTH'({2'b00, cur_id_reg, Local_PC});
    assign Cur_Id       = cur_id_reg;
    assign Load_PC      = load_pc_reg;
    assign Load_Offset  = load_offset_reg;
    assign Stall        = stall_reg;
    assign Switch_Cause = cause_reg;
    assign Last_Id      = last_id_reg;
    assign Done_Mask    = done_mask_w;
    assign All_Done     = &done_mask_w;
    assign Dispatch_Err = err_reg;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an event-level model.
module tb_process_scheduler;

    localparam int AW = 13;
    localparam int OW = 9;
    localparam int Q  = 4;

    logic          Fast_Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          Enable = 1'b0;
    logic [OW-1:0] Local_PC = '0;
    logic [OW-1:0] Next_Local_PC = '0;
    logic          Syscall = 1'b0;
    logic          Halt = 1'b0;
    logic          Dispatch = 1'b0;
    logic [1:0]    Dispatch_Id = 2'd0;
    logic [AW-1:0] PC;
    logic [1:0]    Cur_Id;
    logic          Load_PC;
    logic [OW-1:0] Load_Offset;
    logic          Stall;
    logic [1:0]    Switch_Cause;
    logic [1:0]    Last_Id;
    logic [2:0]    Done_Mask;
    logic          All_Done;
    logic          Dispatch_Err;

    process_scheduler #(.ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .QUANTUM(Q)) dut (
        .Fast_Clock   (Fast_Clock),
        .Reset        (Reset),
        .Enable       (Enable),
        .Local_PC     (Local_PC),
        .Next_Local_PC(Next_Local_PC),
        .Syscall      (Syscall),
        .Halt         (Halt),
        .Dispatch     (Dispatch),
        .Dispatch_Id  (Dispatch_Id),
        .PC           (PC),
        .Cur_Id       (Cur_Id),
        .Load_PC      (Load_PC),
        .Load_Offset  (Load_Offset),
        .Stall        (Stall),
        .Switch_Cause (Switch_Cause),
        .Last_Id      (Last_Id),
        .Done_Mask    (Done_Mask),
        .All_Done     (All_Done),
        .Dispatch_Err (Dispatch_Err)
    );

    always #5 Fast_Clock = ~Fast_Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who runs, whether a one-cycle switch is in flight, and per-process bookkeeping.
    int m_cur, m_last, m_cause, m_load, m_used, m_id;
    bit m_switching, m_err;
    int m_saved [4];
    bit m_done  [3];

    task automatic m_exit(input int cause);
        m_cause     = cause;
        m_last      = m_cur;
        m_cur       = 0;
        m_load      = 0;
        m_switching = 1;
    endtask

    always @(posedge Fast_Clock or negedge Reset) begin
        if (!Reset) begin
            m_cur = 0; m_last = 0; m_cause = 0; m_load = 0; m_used = 0;
            m_switching = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_saved[i] = 0;
            for (int i = 0; i < 3; i++) m_done[i] = 0;
        end else begin
            m_err = 0;
            if (m_switching) begin
                m_switching = 0;
                m_used = 0;
            end else if (m_cur == 0) begin
                if (Enable && Dispatch) begin
                    m_id = int'(Dispatch_Id);
                    if (m_id >= 1 && m_id <= 3 && !m_done[m_id-1]) begin
                        m_cur = m_id;
                        m_load = m_saved[m_id];
                        m_switching = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (Enable) begin
                m_used++;
                if (Halt) begin
                    m_done[m_cur-1] = 1;
                    m_exit(3);
                end else if (Syscall) begin
                    m_saved[m_cur] = int'(Next_Local_PC);
                    m_exit(2);
                end else if (m_used == Q) begin
                    m_saved[m_cur] = int'(Next_Local_PC);
                    m_exit(1);
                end
            end
        end
    end

    always @(negedge Fast_Clock) begin
        chk("PC",           32'(PC),           32'(m_cur * 512 + int'(Local_PC)));
        chk("Cur_Id",       32'(Cur_Id),       32'(m_cur));
        chk("Load_PC",      32'(Load_PC),      32'(m_switching));
        chk("Stall",        32'(Stall),        32'(m_switching));
        chk("Load_Offset",  32'(Load_Offset),  32'(m_load));
        chk("Switch_Cause", 32'(Switch_Cause), 32'(m_cause));
        chk("Last_Id",      32'(Last_Id),      32'(m_last));
        chk("Done_Mask",    32'(Done_Mask),    32'({m_done[2], m_done[1], m_done[0]}));
        chk("All_Done",     32'(All_Done),     32'(m_done[0] & m_done[1] & m_done[2]));
        chk("Dispatch_Err", 32'(Dispatch_Err), 32'(m_err));
    end

    task automatic cyc(input bit en, input bit sys, input bit hlt, input bit dsp,
                       input logic [1:0] id, input logic [OW-1:0] nxt);
        Enable = en; Syscall = sys; Halt = hlt; Dispatch = dsp;
        Dispatch_Id = id; Next_Local_PC = nxt;
        @(posedge Fast_Clock); #2;
        Enable = 0; Syscall = 0; Halt = 0; Dispatch = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 2'd0, '0);
    endtask

    task automatic settle();
        @(negedge Fast_Clock); #1;
    endtask

    initial begin
        repeat (3) @(posedge Fast_Clock);
        #2;
        Reset = 1;
        Local_PC = 5;
        settle();
        chk("lit_reset_PC", 32'(PC), 32'd5);
        chk("lit_reset_Cur_Id", 32'(Cur_Id), 32'd0);
        chk("lit_reset_Stall", 32'(Stall), 32'd0);
        chk("lit_reset_All_Done", 32'(All_Done), 32'd0);

        cyc(1, 0, 0, 1, 2'd2, '0);
        settle();
        chk("lit_sw2_Load_PC", 32'(Load_PC), 32'd1);
        chk("lit_sw2_Stall", 32'(Stall), 32'd1);
        chk("lit_sw2_Load_Offset", 32'(Load_Offset), 32'd0);
        chk("lit_sw2_Cur_Id", 32'(Cur_Id), 32'd2);

        Local_PC = 7;
        idle();
        settle();
        chk("lit_run2_PC", 32'(PC), 32'd1031);
        chk("lit_run2_Stall", 32'(Stall), 32'd0);

        repeat (3) cyc(1, 0, 0, 0, 2'd0, '0);
        settle();
        chk("lit_q3_Cur_Id", 32'(Cur_Id), 32'd2);
        chk("lit_q3_Stall", 32'(Stall), 32'd0);
        cyc(1, 0, 0, 0, 2'd0, 9'd9);
        settle();
        chk("lit_q4_Cur_Id", 32'(Cur_Id), 32'd0);
        chk("lit_q4_Cause", 32'(Switch_Cause), 32'd1);
        chk("lit_q4_Last_Id", 32'(Last_Id), 32'd2);
        chk("lit_q4_Stall", 32'(Stall), 32'd1);

        idle();
        cyc(1, 0, 0, 1, 2'd2, '0);
        settle();
        chk("lit_redisp2_Load_Offset", 32'(Load_Offset), 32'd9);

        idle();
        cyc(1, 1, 0, 0, 2'd0, 9'd11);
        settle();
        chk("lit_sys_Cause", 32'(Switch_Cause), 32'd2);
        idle();
        cyc(1, 0, 0, 1, 2'd1, '0);
        idle();
        cyc(1, 1, 1, 0, 2'd0, 9'd20);
        settle();
        chk("lit_halt1_Cause", 32'(Switch_Cause), 32'd3);
        chk("lit_halt1_Done", 32'(Done_Mask), 32'd1);
        chk("lit_halt1_Last_Id", 32'(Last_Id), 32'd1);
        idle();
        cyc(1, 0, 0, 1, 2'd1, '0);
        settle();
        chk("lit_done_disp_Err", 32'(Dispatch_Err), 32'd1);
        chk("lit_done_disp_Cur_Id", 32'(Cur_Id), 32'd0);
        chk("lit_done_disp_Load_PC", 32'(Load_PC), 32'd0);
        idle();
        settle();
        chk("lit_err_pulse_end", 32'(Dispatch_Err), 32'd0);

        cyc(1, 0, 0, 1, 2'd0, '0);
        settle();
        chk("lit_disp0_Err", 32'(Dispatch_Err), 32'd1);
        cyc(1, 0, 0, 1, 2'd2, '0);
        settle();
        chk("lit_disp2_Load_Offset", 32'(Load_Offset), 32'd11);
        idle();
        cyc(1, 0, 1, 0, 2'd0, '0);
        idle();
        cyc(1, 0, 0, 1, 2'd3, '0);
        idle();
        cyc(1, 0, 1, 0, 2'd0, '0);
        idle();
        settle();
        chk("lit_all_Done_Mask", 32'(Done_Mask), 32'd7);
        chk("lit_all_All_Done", 32'(All_Done), 32'd1);

        Reset = 0;
        @(posedge Fast_Clock); #2;
        Reset = 1;
        cyc(1, 0, 0, 1, 2'd3, '0);
        idle();
        cyc(1, 1, 0, 0, 2'd0, 9'd30);
        idle();
        cyc(1, 0, 0, 1, 2'd3, '0);
        settle();
        chk("lit_sw3_Load_Offset", 32'(Load_Offset), 32'd30);
        chk("lit_sw3_Cur_Id", 32'(Cur_Id), 32'd3);
        Reset = 0;
        #1;
        chk("lit_rst_sw_Cur_Id", 32'(Cur_Id), 32'd0);
        chk("lit_rst_sw_Load_PC", 32'(Load_PC), 32'd0);
        chk("lit_rst_sw_Stall", 32'(Stall), 32'd0);
        chk("lit_rst_sw_Load_Offset", 32'(Load_Offset), 32'd0);
        chk("lit_rst_sw_Cause", 32'(Switch_Cause), 32'd0);
        @(posedge Fast_Clock); #2;
        Reset = 1;

        for (int n = 0; n < 3000; n++) begin
            Enable        = ($urandom_range(0, 9) < 7);
            Dispatch      = ($urandom_range(0, 1) == 1);
            Dispatch_Id   = 2'($urandom_range(0, 3));
            Syscall       = ($urandom_range(0, 9) == 0);
            Halt          = ($urandom_range(0, 19) == 0);
            Local_PC      = OW'($urandom);
            Next_Local_PC = OW'($urandom);
            if (m_done[0] && m_done[1] && m_done[2])
                Reset = ($urandom_range(0, 19) != 0);
            else
                Reset = ($urandom_range(0, 299) != 0);
            @(posedge Fast_Clock); #2;
        end
        Reset = 1;
        idle();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
